serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Parallel-to-serial front end for the serial sequence-detector FSM. It accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, on `ser_out`. That output drives the detector's single-bit input directly. The stream is gap-free across back-to-back words, can be stalled by the consumer, and optionally carries a trailing even-parity bit.

## Interface
- `WIDTH`, default 16: word length in bits, minimum 2.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `load_valid`  in  1: producer presents `load_data`.
- `load_data`  in  WIDTH: word to serialize, bit WIDTH-1 sent first.
- `load_ready`  out  1: feeder accepts the word this cycle.
- `stall`  in  1: consumer freeze request.
- `ser_out`  out  1: current serial bit, registered.
- `ser_valid`  out  1: `ser_out` carries a live bit this cycle.
- `ser_last`  out  1: `ser_out` is the final bit of the current word.
- `busy`  out  1: a word is in flight.

## Operation
- State machine has three states.
  - IDLE: `load_ready`=1. On accept, load the shift register, set the count to WIDTH, present bit WIDTH-1 the next cycle, and go to SHIFT.
  - SHIFT: each non-stalled cycle, shift left by 1 and decrement the count.
    - At count 1 with no parity: accept the next word if `load_valid` and stay in SHIFT; otherwise go to IDLE.
    - With parity: go to PARITY.
  - PARITY: present the parity bit (XOR of all WIDTH data bits) with `ser_last`=1. If not stalled, accept the next word (go to SHIFT) or go to IDLE.
- A handshake completes only when `load_valid` && `load_ready` are high on the same rising edge. `load_data` is captured on that edge only.
- `load_ready` = IDLE, or (final-bit cycle && !`stall`). The producer never sees ready while a non-final bit is pending.
- Stall (`stall`=1 in SHIFT or PARITY):
  - Shift register, counter and state are held.
  - `ser_out` is held at its current value.
  - `ser_valid`=0, `ser_last`=0, `load_ready`=0.
  - In IDLE, `stall` has no effect.
- Count width is $clog2(WIDTH+1). The counter never wraps below 1 in SHIFT.
- `busy` = state != IDLE.
- Every output is 0 in IDLE, except `load_ready`.
- Reset mid-word discards the word. No partial bits are emitted after reset release.

## Timing
- Reset values:
  - `ser_out`=0, `ser_valid`=0, `ser_last`=0, `busy`=0.
  - `load_ready`=1 (IDLE).
  - All take effect asynchronously on `rst` assertion.
- Latency: accept edge N gives the first bit valid in cycle N+1. The last data bit is valid in cycle N+WIDTH, or N+WIDTH+1 for the parity bit when no stall occurs.
- Throughput: back-to-back words produce WIDTH (or WIDTH+1) valid cycles per word with zero bubbles.
- Each stall cycle adds exactly one cycle of latency.
- `ser_last` asserts for exactly one non-stalled cycle per word.

## Configuration
- Macro: `SERIAL_WORD_FEEDER_PARITY_EN`.
- Defined: PARITY state present and every word carries a WIDTH+1-th even-parity bit.
- Undefined: PARITY state and its logic are absent, and `ser_last` marks data bit 0.

## Structure
- Shared package `serial_pkg` holds:
  - state enum `feeder_state_t` (IDLE, SHIFT, PARITY);
  - constant `FEEDER_DEFAULT_WIDTH`=16.
- Sub-module `feeder_bit_counter`: loadable down-counter with hold enable and an `is_last` flag (count==1). The FSM and shift register stay in the top module.

## Test plan
- Single word, no parity:
  - Stimulus: accept `load_data`=16'h5772.
  - Response: `ser_out` over cycles 1..16 = 0,1,0,1,0,1,1,1,0,1,1,1,0,0,1,0. `ser_last` high only in cycle 16. Cycle 17 returns to IDLE with `ser_valid`=0.
- Parity build, same word (9 ones): the bits above are followed by parity bit 1 in cycle 17, which is the `ser_last` cycle.
- Back-to-back:
  - Stimulus: `load_valid` held with 16'hFFFF then 16'h0000.
  - Response: 32 contiguous `ser_valid` cycles, 16 ones then 16 zeros. `load_ready` pulses in cycle 16.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles while bit 11 of 16'h5772 is presented.
  - Response: `ser_out` holds 0 and `ser_valid`=0 during the stall. The word completes in cycle 19.
- Load while busy: `load_valid` pulsed with 16'hAAAA at bit 5 of a word is not accepted, and the in-flight word is unchanged.
- Reset mid-word:
  - Stimulus: assert `rst` at bit 8.
  - Response: all outputs 0 immediately, `load_ready`=1 after release, and no remaining bits are emitted.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word feeder and its counter.
package serial_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } feeder_state_t;

  localparam int FEEDER_DEFAULT_WIDTH = 16;
endpackage

// File: rtl/serial_word_feeder_if.sv
// Word load handshake, consumer stall and serial output bundle; master drives words, slave is the feeder.
interface serial_word_feeder_if
  import serial_pkg::*;
#(
  parameter int WIDTH = FEEDER_DEFAULT_WIDTH
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             stall;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_valid, load_data, stall,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_valid, load_data, stall,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/feeder_bit_counter.sv
// Loadable bits-remaining down-counter; one-cycle update, hold freezes it, saturates at 1.
module feeder_bit_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          hold,
  output logic [CW-1:0] count,
  output logic          is_last
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count > CW'(1))) begin
      count <= count - CW'(1);
    end
  end

  assign is_last = (count == CW'(1));
endmodule

// File: rtl/serial_word_feeder.sv
// MSB-first word serializer: first bit one cycle after accept, ready only when idle or on an unstalled final bit;
// stall freezes the stream. SERIAL_WORD_FEEDER_PARITY_EN appends a trailing even-parity bit per word.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = FEEDER_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_feeder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  feeder_state_t    state, state_nxt;
  logic [WIDTH-2:0] sreg;
  logic             ser_q;
  logic [CW-1:0]    cnt;
  logic             is_last;
  logic             accept, shift_en, clear_out;
  logic             ready_c, valid_c, last_c;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
  logic             par_q;
  logic             to_par;
`endif

  feeder_bit_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CW'(WIDTH)),
    .hold     (!shift_en),
    .count    (cnt),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    clear_out = 1'b0;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    last_c    = 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    to_par    = 1'b0;
`endif
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.load_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!bus.stall) begin
          valid_c = 1'b1;
          if (is_last) begin
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
            to_par    = 1'b1;
            state_nxt = PARITY;
`else
            // Final data bit: chain the next word in without a bubble.
            last_c  = 1'b1;
            ready_c = 1'b1;
            if (bus.load_valid) begin
              accept = 1'b1;
            end else begin
              clear_out = 1'b1;
              state_nxt = IDLE;
            end
`endif
          end else begin
            shift_en = 1'b1;
          end
        end
      end
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      PARITY: begin
        if (!bus.stall) begin
          valid_c = 1'b1;
          last_c  = 1'b1;
          ready_c = 1'b1;
          if (bus.load_valid) begin
            accept    = 1'b1;
            state_nxt = SHIFT;
          end else begin
            clear_out = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // ser_q is the presented bit; sreg holds the bits still to come, next one at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      ser_q <= 1'b0;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (accept) begin
      sreg  <= bus.load_data[WIDTH-2:0];
      ser_q <= bus.load_data[WIDTH-1];
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
      par_q <= ^bus.load_data;
`endif
    end else if (shift_en) begin
      sreg  <= sreg << 1;
      ser_q <= sreg[WIDTH-2];
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
    end else if (to_par) begin
      ser_q <= par_q;
`endif
    end else if (clear_out) begin
      ser_q <= 1'b0;
    end
  end

  assign bus.load_ready = ready_c;
  assign bus.ser_valid  = valid_c;
  assign bus.ser_last   = last_c;
  assign bus.ser_out    = ser_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed scenarios plus random traffic against a bit-queue reference model.
module tb_serial_word_feeder;
  import serial_pkg::*;

  localparam int W = FEEDER_DEFAULT_WIDTH;
`ifdef SERIAL_WORD_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WL = W + PAR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_feeder_if #(.WIDTH(W)) bus ();
  serial_word_feeder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the bits still owed to the consumer for the word in flight, in send order.
  bit exp_bits[$];

  function automatic bit m_ready();
    return (exp_bits.size() == 0) || (exp_bits.size() == 1 && !bus.stall);
  endfunction

  // Packed as {ser_out, ser_valid, ser_last, load_ready, busy}.
  function automatic logic [4:0] m_outs();
    logic [4:0] v;
    v[4] = (exp_bits.size() > 0) ? exp_bits[0] : 1'b0;
    v[3] = (exp_bits.size() > 0) && !bus.stall;
    v[2] = (exp_bits.size() == 1) && !bus.stall;
    v[1] = m_ready();
    v[0] = (exp_bits.size() > 0);
    return v;
  endfunction

  function automatic logic [4:0] d_outs();
    return {bus.ser_out, bus.ser_valid, bus.ser_last, bus.load_ready, bus.busy};
  endfunction

  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    if (PAR != 0) exp_bits.push_back(^d);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit s);
    bus.load_valid = v;
    bus.load_data  = d;
    bus.stall      = s;
  endtask

  // Advance one clock and update the model with what the inputs did at that edge.
  task automatic tick(output bit acc);
    logic [W-1:0] d;
    bit           s;
    acc = bus.load_valid && m_ready();
    d   = bus.load_data;
    s   = bus.stall;
    @(posedge clk);
    if (exp_bits.size() > 0 && !s) exp_bits.delete(0);
    if (acc) push_word(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    #2;
    n_checks++;
    if (d_outs() !== 5'b00010) begin
      n_errors++;
      $display("FAIL reset_asserted got=%b exp=%b", d_outs(), 5'b00010);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (d_outs() !== 5'b00010) begin
      n_errors++;
      $display("FAIL reset_released got=%b exp=%b", d_outs(), 5'b00010);
    end
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [W-1:0] got = '0;
    int  last_cyc = -1;
    bit  par_bit  = 1'b0;
    bit  after_v  = 1'b1;
    bit  acc;
    for (int c = 0; c < WL + 4; c++) begin
      drive(c == 0, 16'h5772, 1'b0);
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL single_word c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      if (bus.ser_valid && c >= 1 && c <= W) got[W-c] = bus.ser_out;
      if (c == W + 1) par_bit = bus.ser_out;
      if (c == WL + 1) after_v = bus.ser_valid;
      if (bus.ser_last) last_cyc = c;
      tick(acc);
    end
    n_checks++;
    if (got !== 16'h5772) begin
      n_errors++;
      $display("FAIL single_word_bits got=%h exp=%h", got, 16'h5772);
    end
    n_checks++;
    if (last_cyc != WL) begin
      n_errors++;
      $display("FAIL single_word_last got=%0d exp=%0d", last_cyc, WL);
    end
    n_checks++;
    if (after_v !== 1'b0) begin
      n_errors++;
      $display("FAIL single_word_idle got=%b exp=0", after_v);
    end
    if (PAR != 0) begin
      n_checks++;
      if (par_bit !== 1'b1) begin
        n_errors++;
        $display("FAIL parity_bit got=%b exp=1", par_bit);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, nv = 0, first = -1, lastv = -1, bad = 0, rp = 0, rc = -1;
    bit acc;
    for (int c = 0; c < 2 * WL + 4; c++) begin
      drive(n_acc < 2, (n_acc == 0) ? 16'hFFFF : 16'h0000, 1'b0);
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      if (bus.ser_valid) begin
        if (((nv % WL) < W) && (bus.ser_out !== ((nv / WL) == 0))) bad++;
        nv++;
        if (first < 0) first = c;
        lastv = c;
      end
      if (c > 0 && c < 2 * WL && bus.load_ready) begin
        rp++;
        rc = c;
      end
      tick(acc);
      if (acc) n_acc++;
    end
    n_checks++;
    if (nv != 2 * WL || lastv - first + 1 != nv || first != 1) begin
      n_errors++;
      $display("FAIL back_to_back_run got=%0d/%0d..%0d exp=%0d/1..%0d", nv, first, lastv, 2 * WL, 2 * WL);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL back_to_back_data got=%0d bad bits exp=0", bad);
    end
    n_checks++;
    if (rp != 1 || rc != WL) begin
      n_errors++;
      $display("FAIL back_to_back_ready got=%0d pulses at %0d exp=1 at %0d", rp, rc, WL);
    end
  endtask

  task automatic test_stall();
    int last_cyc = -1, bad = 0;
    bit acc;
    for (int c = 0; c < WL + 7; c++) begin
      drive(c == 0, 16'h5772, (c >= 5 && c <= 7));
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL stall c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      if (c >= 5 && c <= 7 && (bus.ser_out !== 1'b0 || bus.ser_valid !== 1'b0)) bad++;
      if (bus.ser_last) last_cyc = c;
      tick(acc);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL stall_hold got=%0d bad cycles exp=0", bad);
    end
    n_checks++;
    if (last_cyc != WL + 3) begin
      n_errors++;
      $display("FAIL stall_last got=%0d exp=%0d", last_cyc, WL + 3);
    end
  endtask

  task automatic test_load_busy();
    logic [W-1:0] got = '0;
    bit rdy_busy = 1'b1;
    bit acc;
    for (int c = 0; c < WL + 4; c++) begin
      if (c == 11) drive(1'b1, 16'hAAAA, 1'b0);
      else         drive(c == 0, 16'h5772, 1'b0);
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL load_busy c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      if (c == 11) rdy_busy = bus.load_ready;
      if (bus.ser_valid && c >= 1 && c <= W) got[W-c] = bus.ser_out;
      tick(acc);
    end
    n_checks++;
    if (rdy_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL load_busy_ready got=%b exp=0", rdy_busy);
    end
    n_checks++;
    if (got !== 16'h5772) begin
      n_errors++;
      $display("FAIL load_busy_bits got=%h exp=%h", got, 16'h5772);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    bit acc;
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, 16'h5772, 1'b0);
      #1;
      tick(acc);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (d_outs() !== 5'b00010) begin
      n_errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", d_outs(), 5'b00010);
    end
    exp_bits.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < WL + 2; c++) begin
      drive(1'b0, '0, 1'b0);
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      if (bus.ser_valid) nv++;
      tick(acc);
    end
    n_checks++;
    if (nv != 0) begin
      n_errors++;
      $display("FAIL reset_mid_bits got=%0d exp=0", nv);
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) == 0));
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL random c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      tick(acc);
    end
    for (int c = 0; c < WL + 3; c++) begin
      drive(1'b0, '0, 1'b0);
      #1;
      n_checks++;
      if (d_outs() !== m_outs()) begin
        n_errors++;
        $display("FAIL random_drain c=%0d got=%b exp=%b", c, d_outs(), m_outs());
      end
      tick(acc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_load_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
